box_slave: RTL and testbench

AXI3-style write responder, the receive end of the box write path.
- Accepts one AW burst descriptor and its W beats.
- Assembles them into a spec_slot: header fields plus packed data/strb of up to MAX_BEATS beats.
- Presents the slot to downstream special memory with a valid/ready handshake, then returns the B response.
- Handles one outstanding burst at a time; sits between the AXI interconnect and the slot store.

---
 rtl/box_slave_pkg.sv | 38 +++
 rtl/box_slave_beat_buf.sv | 36 +++
 rtl/box_slave.sv | 140 ++++++++++++++
 tb/tb_box_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/box_slave_pkg.sv
// Shared types and widths for the box write path (box_master / box_slave).
// MAX_BEATS is derived from LEN_WIDTH so a full awlen range always fits the slot.
package box_slave_pkg;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int LEN_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_BEATS  = 1 << LEN_WIDTH;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_SLOT,
    S_RESP
  } slave_state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]              awid;
    logic [ADDR_WIDTH-1:0]            awaddr;
    logic [LEN_WIDTH-1:0]             awlen;
    logic [2:0]                       awsize;
    logic [1:0]                       awburst;
    logic [3:0]                       awuser;
    logic [MAX_BEATS*DATA_WIDTH-1:0]  data;
    logic [MAX_BEATS*STRB_WIDTH-1:0]  strb;
  } spec_slot;

  function automatic logic is_final_beat(input logic [LEN_WIDTH:0] cnt,
                                         input logic [LEN_WIDTH-1:0] len);
    return cnt == {1'b0, len};
  endfunction

endpackage

// File: rtl/box_slave_beat_buf.sv
// Beat-indexed data/strb storage for one burst; clear wins over write.
// Unwritten lanes read back as zero.
module box_slave_beat_buf
  import box_slave_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clr,
  input  logic                            i_we,
  input  logic [LEN_WIDTH-1:0]            i_idx,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic [STRB_WIDTH-1:0]           i_strb,
  output logic [MAX_BEATS*DATA_WIDTH-1:0] o_data,
  output logic [MAX_BEATS*STRB_WIDTH-1:0] o_strb
);

  logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] r_data;
  logic [MAX_BEATS-1:0][STRB_WIDTH-1:0] r_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (i_we) begin
      r_data[i_idx] <= i_data;
      r_strb[i_idx] <= i_strb;
    end
  end

  assign o_data = r_data;
  assign o_strb = r_strb;

endmodule

// File: rtl/box_slave.sv
// AXI3-style write responder: one burst at a time, assembled into a spec_slot,
// handed downstream, then answered on B. Errors are sticky per burst.
module box_slave
  import box_slave_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [LEN_WIDTH-1:0]  awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [3:0]            awuser,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [ID_WIDTH-1:0]   wid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  slot_valid,
  input  logic                  slot_ready,
  output spec_slot              out_slot,
  output logic                  slot_err
);

  slave_state_e          r_state;
  logic                  r_awready, r_wready, r_bvalid, r_slot_valid, r_slot_err, r_err;
  logic [ID_WIDTH-1:0]   r_bid, r_awid;
  logic [1:0]            r_bresp, r_awburst;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [LEN_WIDTH-1:0]  r_awlen;
  logic [2:0]            r_awsize;
  logic [3:0]            r_awuser;
  logic [LEN_WIDTH:0]    r_cnt;

  logic w_aw_fire, w_beat_fire, w_final, w_end, w_beat_err;

  assign w_aw_fire   = (r_state == S_IDLE) && awvalid && r_awready;
  assign w_beat_fire = (r_state == S_DATA) && wvalid && r_wready;
  assign w_final     = is_final_beat(r_cnt, r_awlen);
  assign w_end       = wlast || w_final;
  // Early last, missing last and ID mismatch all poison the burst.
  assign w_beat_err  = (wid != r_awid) || (wlast && !w_final) || (!wlast && w_final);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_awready    <= 1'b1;
      r_wready     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_slot_valid <= 1'b0;
      r_slot_err   <= 1'b0;
      r_err        <= 1'b0;
      r_bid        <= '0;
      r_bresp      <= BRESP_OKAY;
      r_awid       <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awsize     <= '0;
      r_awburst    <= '0;
      r_awuser     <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_aw_fire) begin
          r_awid    <= awid;
          r_awaddr  <= awaddr;
          r_awlen   <= awlen;
          r_awsize  <= awsize;
          r_awburst <= awburst;
          r_awuser  <= awuser;
          r_err     <= 1'b0;
          r_cnt     <= '0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_state   <= S_DATA;
        end
        S_DATA: if (w_beat_fire) begin
          if (w_beat_err) r_err <= 1'b1;
          if (w_end) begin
            r_wready     <= 1'b0;
            r_slot_valid <= 1'b1;
            r_slot_err   <= r_err || w_beat_err;
            r_state      <= S_SLOT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SLOT: if (slot_ready) begin
          r_slot_valid <= 1'b0;
          r_slot_err   <= 1'b0;
          r_bvalid     <= 1'b1;
          r_bid        <= r_awid;
          r_bresp      <= r_err ? BRESP_SLVERR : BRESP_OKAY;
          r_state      <= S_RESP;
        end
        S_RESP: if (bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  box_slave_beat_buf u_beat_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_aw_fire),
    .i_we   (w_beat_fire),
    .i_idx  (r_cnt[LEN_WIDTH-1:0]),
    .i_data (wdata),
    .i_strb (wstrb),
    .o_data (out_slot.data),
    .o_strb (out_slot.strb)
  );

  assign out_slot.awid    = r_awid;
  assign out_slot.awaddr  = r_awaddr;
  assign out_slot.awlen   = r_awlen;
  assign out_slot.awsize  = r_awsize;
  assign out_slot.awburst = r_awburst;
  assign out_slot.awuser  = r_awuser;

  assign awready    = r_awready;
  assign wready     = r_wready;
  assign bvalid     = r_bvalid;
  assign bid        = r_bid;
  assign bresp      = r_bresp;
  assign slot_valid = r_slot_valid;
  assign slot_err   = r_slot_err;

endmodule

// File: tb/tb_box_slave.sv
// Scoreboard bench for box_slave: expected slots/responses are queued as bursts
// are driven and compared when the DUT presents them.
module tb_box_slave;
  import box_slave_pkg::*;

  typedef logic [639:0] v_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  awvalid = 1'b0, awready;
  logic [ID_WIDTH-1:0]   awid = '0;
  logic [ADDR_WIDTH-1:0] awaddr = '0;
  logic [LEN_WIDTH-1:0]  awlen = '0;
  logic [2:0]            awsize = '0;
  logic [1:0]            awburst = '0;
  logic [3:0]            awuser = '0;
  logic                  wvalid = 1'b0, wready;
  logic [ID_WIDTH-1:0]   wid = '0;
  logic [DATA_WIDTH-1:0] wdata = '0;
  logic [STRB_WIDTH-1:0] wstrb = '0;
  logic                  wlast = 1'b0;
  logic                  bvalid, bready = 1'b0;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  slot_valid, slot_ready = 1'b0;
  spec_slot              out_slot;
  logic                  slot_err;

  always #5 clk = ~clk;

  box_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awuser(awuser),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .slot_valid(slot_valid), .slot_ready(slot_ready), .out_slot(out_slot), .slot_err(slot_err)
  );

  typedef struct {
    spec_slot            slot;
    logic                err;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input v_t act, input v_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return awready;
      1:       return wready;
      2:       return slot_valid;
      default: return bvalid;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the signal high or the budget spent.
  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, v_t'(sig(which)), v_t'(1'b1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".awready"},    v_t'(awready),    v_t'(1'b1));
    chk({tag, ".wready"},     v_t'(wready),     v_t'(1'b0));
    chk({tag, ".bvalid"},     v_t'(bvalid),     v_t'(1'b0));
    chk({tag, ".slot_valid"}, v_t'(slot_valid), v_t'(1'b0));
    chk({tag, ".slot_err"},   v_t'(slot_err),   v_t'(1'b0));
    chk({tag, ".bresp"},      v_t'(bresp),      v_t'(2'b00));
    chk({tag, ".bid"},        v_t'(bid),        v_t'(4'h0));
    chk({tag, ".out_slot"},   v_t'(out_slot),   v_t'(0));
  endtask

  function automatic logic [DATA_WIDTH-1:0] data_of(input logic [31:0] base, input int k);
    return base * 32'(k + 1);
  endfunction

  function automatic logic [STRB_WIDTH-1:0] strb_of(input logic [3:0] id, input int k);
    return (id == 4'd5) ? 4'hF : 4'(k + 3);
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [3:0] len, input logic [31:0] base);
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = base ^ 32'h8000_0000; awlen = len;
    awsize = 3'd2; awburst = 2'b01; awuser = id ^ 4'hA;
    wait_sig(0, "aw_accept");
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("wready_lat", v_t'(wready), v_t'(1'b1));
  endtask

  // Drives beats 0..nb-1 starting at the current negedge; returns #1 after the last accept.
  task automatic w_send(input logic [3:0] id, input int nb, input int last_at,
                        input int bad_at, input logic [31:0] base);
    for (int k = 0; k < nb; k++) begin
      if (k > 0) @(negedge clk);
      wvalid = 1'b1;
      wid    = (k == bad_at) ? id + 4'd1 : id;
      wdata  = data_of(base, k);
      wstrb  = strb_of(id, k);
      wlast  = (k == last_at);
      wait_sig(1, "w_accept");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic burst(input logic [3:0] id, input logic [3:0] len, input int last_at,
                       input int bad_at, input logic [31:0] base, input int slot_hold,
                       input int b_hold, input bit extra_beat);
    exp_t e, got;
    int   nb;
    nb = (last_at <= int'(len)) ? last_at + 1 : int'(len) + 1;
    e.slot = '0;
    e.slot.awid = id; e.slot.awaddr = base ^ 32'h8000_0000; e.slot.awlen = len;
    e.slot.awsize = 3'd2; e.slot.awburst = 2'b01; e.slot.awuser = id ^ 4'hA;
    for (int k = 0; k < nb; k++) begin
      e.slot.data[k*DATA_WIDTH +: DATA_WIDTH] = data_of(base, k);
      e.slot.strb[k*STRB_WIDTH +: STRB_WIDTH] = strb_of(id, k);
    end
    e.err   = (last_at != int'(len)) || (bad_at >= 0 && bad_at < nb);
    e.bid   = id;
    e.bresp = e.err ? 2'b10 : 2'b00;
    sb.push_back(e);

    aw_send(id, len, base);
    w_send(id, nb, last_at, bad_at, base);
    if (extra_beat) begin
      wvalid = 1'b1; wid = id; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    end
    @(negedge clk);
    chk("slot_lat", v_t'(slot_valid), v_t'(1'b1));
    if (extra_beat) chk("extra_beat_wready", v_t'(wready), v_t'(1'b0));
    wvalid = 1'b0;

    if (slot_hold > 0) awvalid = 1'b1;
    for (int i = 0; i < slot_hold; i++) begin
      chk("slot_hold_valid", v_t'(slot_valid), v_t'(1'b1));
      chk("slot_hold_data", v_t'(out_slot), v_t'(e.slot));
      chk("slot_hold_awready", v_t'(awready), v_t'(1'b0));
      @(negedge clk);
    end

    slot_ready = 1'b1;
    wait_sig(2, "slot_valid");
    got = sb.pop_front();
    chk("slot", v_t'(out_slot), v_t'(got.slot));
    chk("slot_err", v_t'(slot_err), v_t'(got.err));
    @(posedge clk); #1;
    slot_ready = 1'b0;
    @(negedge clk);
    chk("b_lat", v_t'(bvalid), v_t'(1'b1));
    chk("slot_drop", v_t'(slot_valid), v_t'(1'b0));

    for (int i = 0; i < b_hold; i++) begin
      chk("b_hold_valid", v_t'(bvalid), v_t'(1'b1));
      chk("b_hold_awready", v_t'(awready), v_t'(1'b0));
      @(negedge clk);
    end

    bready = 1'b1;
    wait_sig(3, "bvalid");
    chk("bid", v_t'(bid), v_t'(got.bid));
    chk("bresp", v_t'(bresp), v_t'(got.bresp));
    @(posedge clk); #1;
    bready = 1'b0; awvalid = 1'b0;
    @(negedge clk);
    chk("awready_back", v_t'(awready), v_t'(1'b1));
    chk("b_drop", v_t'(bvalid), v_t'(1'b0));
  endtask

  initial begin
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores W traffic
    wvalid = 1'b1; wid = 4'd1; wdata = 32'hBAD0_0001; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clk);
    chk("idle_wready", v_t'(wready), v_t'(1'b0));
    wvalid = 1'b0; wlast = 1'b0;

    burst(4'd5, 4'd3, 3,  -1, 32'h0000_0011, 0,  0, 1'b0);
    burst(4'd2, 4'd0, 0,  -1, 32'hA5A5_0001, 0,  0, 1'b1);
    burst(4'd7, 4'd3, 1,  -1, 32'h1234_0007, 0,  0, 1'b0);
    burst(4'd5, 4'd2, 2,   1, 32'h0BAD_F00D, 0,  0, 1'b0);
    burst(4'd9, 4'd3, 99, -1, 32'h3C3C_0101, 0,  0, 1'b0);
    burst(4'd4, 4'd15, 15, -1, 32'h0101_0101, 10, 5, 1'b0);
    burst(4'd1, 4'd1, 1,  -1, 32'h7777_0003, 0,  0, 1'b0);

    // Reset in the middle of a burst: nothing of it may survive
    aw_send(4'd3, 4'd3, 32'h5555_0000);
    w_send(4'd3, 2, 3, -1, 32'h5555_0000);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    burst(4'd3, 4'd1, 1, -1, 32'h0000_2222, 0, 0, 1'b0);

    chk("sb_empty", v_t'(sb.size()), v_t'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
